// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: opcodes, default widths and the ROB entry payload.
package tomasulo_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned INST_W = 16;

    localparam logic [OP_W-1:0] OP_SUB   = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD   = 4'b0001;
    localparam logic [OP_W-1:0] OP_MUL   = 4'b0010;
    localparam logic [OP_W-1:0] OP_DIV   = 4'b0011;
    localparam logic [OP_W-1:0] OP_STORE = 4'b0100;
    localparam logic [OP_W-1:0] OP_LOAD  = 4'b0101;

    typedef struct packed {
        logic              busy;
        logic              done;
        logic [OP_W-1:0]   opcode;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] value;
    } rob_entry_t;

    // True for opcodes that retire to memory rather than the register file.
    function automatic logic is_store(input logic [OP_W-1:0] op);
        return op == OP_STORE;
    endfunction

endpackage

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate, CDB capture, operand lookup,
// in-order retirement and full flush.
module rob_param #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned TAG_W  = $clog2(DEPTH),
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REG_W  = 4,
    parameter int unsigned OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [OP_W-1:0]   alloc_opcode,
    input  logic [REG_W-1:0]  alloc_dest,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [DATA_W-1:0] wb_value,
    input  logic [TAG_W-1:0]  rd_tag_a,
    input  logic [TAG_W-1:0]  rd_tag_b,
    output logic              rd_ready_a,
    output logic              rd_ready_b,
    output logic [DATA_W-1:0] rd_value_a,
    output logic [DATA_W-1:0] rd_value_b,
    output logic              commit_valid,
    input  logic              commit_ready,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [OP_W-1:0]   commit_opcode,
    output logic [REG_W-1:0]  commit_dest,
    output logic [DATA_W-1:0] commit_value,
    output logic              commit_reg_we,
    output logic [TAG_W:0]    count,
    output logic              full,
    output logic              empty
);

    import tomasulo_pkg::*;

    localparam int unsigned CNT_W = TAG_W + 1;

    // Per-entry state; busy/done are reset, payload fields are not.
    logic [DEPTH-1:0]  ent_busy;
    logic [DEPTH-1:0]  ent_done;
    logic [OP_W-1:0]   ent_opcode [DEPTH];
    logic [REG_W-1:0]  ent_dest   [DEPTH];
    logic [DATA_W-1:0] ent_value  [DEPTH];

    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic [CNT_W-1:0]  count_q;

    logic              alloc_fire;
    logic              commit_fire;
    logic              wb_hit;

    // Operand lookup with same-cycle CDB bypass; returns {ready, value}.
    function automatic logic [DATA_W:0] lookup(
        input logic              busy_t,
        input logic              done_t,
        input logic [DATA_W-1:0] value_t,
        input logic              bypass_t,
        input logic [DATA_W-1:0] bypass_value
    );
        logic              ready;
        logic [DATA_W-1:0] value;
        ready = 1'b0;
        value = '0;
        if (busy_t) begin
            ready = done_t || bypass_t;
            value = bypass_t ? bypass_value : value_t;
        end
        return {ready, value};
    endfunction

    // Occupancy flags and handshake decode.
    always_comb begin
        full         = (count_q == CNT_W'(DEPTH));
        empty        = (count_q == '0);
        count        = count_q;
        alloc_ready  = !full;
        alloc_tag    = tail;
        alloc_fire   = alloc_valid && !full;
        wb_hit       = wb_valid && ent_busy[wb_tag];
        commit_valid = !empty && ent_done[head];
        commit_fire  = commit_valid && commit_ready;
    end

    // Head entry presented to the retirement consumer.
    always_comb begin
        commit_tag    = head;
        commit_opcode = ent_opcode[head];
        commit_dest   = ent_dest[head];
        commit_value  = ent_value[head];
        commit_reg_we = commit_valid && (ent_opcode[head] != OP_W'(OP_STORE));
    end

    // Two reservation-station lookup ports.
    always_comb begin
        {rd_ready_a, rd_value_a} = lookup(ent_busy[rd_tag_a], ent_done[rd_tag_a],
                                          ent_value[rd_tag_a],
                                          wb_valid && (wb_tag == rd_tag_a), wb_value);
        {rd_ready_b, rd_value_b} = lookup(ent_busy[rd_tag_b], ent_done[rd_tag_b],
                                          ent_value[rd_tag_b],
                                          wb_valid && (wb_tag == rd_tag_b), wb_value);
    end

    // Control state: pointers, count and busy/done bits; reset then flush win.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            ent_busy <= '0;
            ent_done <= '0;
            head     <= '0;
            tail     <= '0;
            count_q  <= '0;
        end else begin
            if (wb_hit) begin
                ent_done[wb_tag] <= 1'b1;
            end
            if (alloc_fire) begin
                ent_busy[tail] <= 1'b1;
                ent_done[tail] <= 1'b0;
                tail           <= tail + TAG_W'(1);
            end
            if (commit_fire) begin
                ent_busy[head] <= 1'b0;
                ent_done[head] <= 1'b0;
                head           <= head + TAG_W'(1);
            end
            count_q <= count_q + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
        end
    end

    // Payload capture; contents of free slots are don't-care so no reset.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            ent_opcode[tail] <= alloc_opcode;
            ent_dest[tail]   <= alloc_dest;
        end
        if (wb_hit) begin
            ent_value[wb_tag] <= wb_value;
        end
    end

    // A second writeback to a completed entry indicates a CDB protocol error.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && wb_hit) begin
            assert (!ent_done[wb_tag])
                else $error("rob_param: writeback to already-completed tag %0d", wb_tag);
        end
    end

endmodule

// File: tb/tb_rob_param.sv
// Self-checking bench for rob_param: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model.
module tb_rob_param;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned TAG_W  = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned OP_W   = 4;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              alloc_valid;
    logic              alloc_ready;
    logic [OP_W-1:0]   alloc_opcode;
    logic [REG_W-1:0]  alloc_dest;
    logic [TAG_W-1:0]  alloc_tag;
    logic              wb_valid;
    logic [TAG_W-1:0]  wb_tag;
    logic [DATA_W-1:0] wb_value;
    logic [TAG_W-1:0]  rd_tag_a;
    logic [TAG_W-1:0]  rd_tag_b;
    logic              rd_ready_a;
    logic              rd_ready_b;
    logic [DATA_W-1:0] rd_value_a;
    logic [DATA_W-1:0] rd_value_b;
    logic              commit_valid;
    logic              commit_ready;
    logic [TAG_W-1:0]  commit_tag;
    logic [OP_W-1:0]   commit_opcode;
    logic [REG_W-1:0]  commit_dest;
    logic [DATA_W-1:0] commit_value;
    logic              commit_reg_we;
    logic [TAG_W:0]    count;
    logic              full;
    logic              empty;

    rob_param #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .REG_W(REG_W), .OP_W(OP_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_opcode(alloc_opcode), .alloc_dest(alloc_dest), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
        .rd_tag_a(rd_tag_a), .rd_tag_b(rd_tag_b),
        .rd_ready_a(rd_ready_a), .rd_ready_b(rd_ready_b),
        .rd_value_a(rd_value_a), .rd_value_b(rd_value_b),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_tag(commit_tag), .commit_opcode(commit_opcode),
        .commit_dest(commit_dest), .commit_value(commit_value),
        .commit_reg_we(commit_reg_we),
        .count(count), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: tags in program order plus per-tag attributes.
    int          order [$];
    int          m_tail;
    bit          m_busy [DEPTH];
    bit          m_done [DEPTH];
    logic [7:0]  m_val  [DEPTH];
    logic [3:0]  m_op   [DEPTH];
    logic [3:0]  m_dest [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        order.delete();
        m_tail = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_busy[i] = 1'b0;
            m_done[i] = 1'b0;
        end
    endtask

    task automatic check_lookup(input string nm, input int t, input logic rdy, input logic [7:0] val);
        bit   byp;
        bit   exp_rdy;
        byp     = wb_valid && (int'(wb_tag) == t);
        exp_rdy = m_busy[t] && (m_done[t] || byp);
        chk({nm, "_ready"}, 32'(rdy), 32'(exp_rdy));
        if (!m_busy[t])
            chk({nm, "_value_idle"}, 32'(val), 32'h0);
        else if (exp_rdy)
            chk({nm, "_value"}, 32'(val), byp ? 32'(wb_value) : 32'(m_val[t]));
    endtask

    task automatic check_all();
        int  h;
        bit  cv;
        h  = (order.size() > 0) ? order[0] : m_tail;
        cv = (order.size() > 0) && m_done[h];
        chk("count", 32'(count), 32'(order.size()));
        chk("empty", 32'(empty), 32'(order.size() == 0));
        chk("full", 32'(full), 32'(order.size() == DEPTH));
        chk("alloc_ready", 32'(alloc_ready), 32'(order.size() < DEPTH));
        chk("alloc_tag", 32'(alloc_tag), 32'(m_tail));
        chk("commit_valid", 32'(commit_valid), 32'(cv));
        if (cv) begin
            chk("commit_tag", 32'(commit_tag), 32'(h));
            chk("commit_opcode", 32'(commit_opcode), 32'(m_op[h]));
            chk("commit_dest", 32'(commit_dest), 32'(m_dest[h]));
            chk("commit_value", 32'(commit_value), 32'(m_val[h]));
            chk("commit_reg_we", 32'(commit_reg_we), 32'(m_op[h] != 4'b0100));
        end else begin
            chk("commit_reg_we_idle", 32'(commit_reg_we), 32'h0);
        end
        check_lookup("rd_a", int'(rd_tag_a), rd_ready_a, rd_value_a);
        check_lookup("rd_b", int'(rd_tag_b), rd_ready_b, rd_value_b);
    endtask

    // One clock: check outputs against the model, then advance the model at the edge.
    task automatic step(input bit do_check);
        bit whit;
        bit afire;
        bit cfire;
        int h;
        #1;
        if (do_check) check_all();
        @(posedge clk);
        if (!rst_n || flush) begin
            model_clear();
        end else begin
            h     = (order.size() > 0) ? order[0] : m_tail;
            whit  = wb_valid && m_busy[wb_tag];
            cfire = commit_ready && (order.size() > 0) && m_done[h];
            afire = alloc_valid && (order.size() < DEPTH);
            if (whit) begin
                m_done[wb_tag] = 1'b1;
                m_val[wb_tag]  = wb_value;
            end
            if (cfire) begin
                void'(order.pop_front());
                m_busy[h] = 1'b0;
                m_done[h] = 1'b0;
            end
            if (afire) begin
                m_busy[m_tail] = 1'b1;
                m_done[m_tail] = 1'b0;
                m_op[m_tail]   = alloc_opcode;
                m_dest[m_tail] = alloc_dest;
                order.push_back(m_tail);
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst_n        = 1'b1;
        flush        = 1'b0;
        alloc_valid  = 1'b0;
        alloc_opcode = '0;
        alloc_dest   = '0;
        wb_valid     = 1'b0;
        wb_tag       = '0;
        wb_value     = '0;
        commit_ready = 1'b0;
        rd_tag_a     = '0;
        rd_tag_b     = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step(1'b1);
        rst_n = 1'b1;
    endtask

    task automatic alloc(input logic [3:0] op, input logic [3:0] dst);
        idle();
        alloc_valid  = 1'b1;
        alloc_opcode = op;
        alloc_dest   = dst;
        step(1'b1);
        idle();
    endtask

    task automatic wb(input int t, input logic [7:0] v);
        idle();
        wb_valid = 1'b1;
        wb_tag   = TAG_W'(t);
        wb_value = v;
        step(1'b1);
        idle();
    endtask

    // Randomized input vector; writebacks only target pending or free tags.
    task automatic rand_inputs();
        int pend [$];
        int r;
        int t;
        idle();
        alloc_valid  = ($urandom_range(0, 9) < 6);
        alloc_opcode = 4'($urandom_range(0, 5));
        alloc_dest   = 4'($urandom);
        commit_ready = ($urandom_range(0, 9) < 7);
        rd_tag_a     = 3'($urandom);
        rd_tag_b     = 3'($urandom);
        flush        = ($urandom_range(0, 199) == 0);
        rst_n        = !($urandom_range(0, 299) == 0);
        wb_value     = 8'($urandom);
        for (int i = 0; i < DEPTH; i++)
            if (m_busy[i] && !m_done[i]) pend.push_back(i);
        r = $urandom_range(0, 9);
        if (r < 5 && pend.size() > 0) begin
            wb_valid = 1'b1;
            wb_tag   = TAG_W'(pend[$urandom_range(0, pend.size() - 1)]);
        end else if (r == 5) begin
            t = $urandom_range(0, DEPTH - 1);
            if (!m_busy[t]) begin
                wb_valid = 1'b1;
                wb_tag   = TAG_W'(t);
            end
        end
    endtask

    initial begin
        model_clear();
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        step(1'b0);
        step(1'b1);
        rst_n = 1'b1;

        // Reset state.
        #1;
        chk("rst_alloc_ready", 32'(alloc_ready), 32'h1);
        chk("rst_alloc_tag", 32'(alloc_tag), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_commit_valid", 32'(commit_valid), 32'h0);
        chk("rst_rd_ready_a", 32'(rd_ready_a), 32'h0);

        // Single ADD r3 through allocate, writeback, commit.
        alloc(4'b0001, 4'd3);
        #1;
        chk("add_count", 32'(count), 32'h1);
        wb(0, 8'h2A);
        commit_ready = 1'b1;
        #1;
        chk("add_commit_valid", 32'(commit_valid), 32'h1);
        chk("add_commit_dest", 32'(commit_dest), 32'h3);
        chk("add_commit_value", 32'(commit_value), 32'h2A);
        chk("add_commit_reg_we", 32'(commit_reg_we), 32'h1);
        step(1'b1);
        idle();
        #1;
        chk("add_empty", 32'(empty), 32'h1);

        // Out-of-order completion retires in program order.
        do_reset();
        alloc(4'b0001, 4'd1);
        alloc(4'b0010, 4'd2);
        alloc(4'b0000, 4'd4);
        wb(2, 8'd11);
        wb(1, 8'd22);
        #1;
        chk("ooo_hold", 32'(commit_valid), 32'h0);
        wb(0, 8'd33);
        commit_ready = 1'b1;
        #1;
        chk("ooo_c0", 32'(commit_value), 32'd33);
        step(1'b1);
        #1;
        chk("ooo_c1", 32'(commit_value), 32'd22);
        step(1'b1);
        #1;
        chk("ooo_c2", 32'(commit_value), 32'd11);
        step(1'b1);
        idle();
        #1;
        chk("ooo_empty", 32'(empty), 32'h1);

        // Fill to full, extra alloc ignored, commit frees a slot for next cycle.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            alloc_valid  = 1'b1;
            alloc_opcode = 4'b0001;
            alloc_dest   = 4'(i);
            #1;
            chk("fill_tag", 32'(alloc_tag), 32'(i));
            step(1'b1);
        end
        #1;
        chk("full_flag", 32'(full), 32'h1);
        chk("full_ready", 32'(alloc_ready), 32'h0);
        chk("full_tail", 32'(alloc_tag), 32'h0);
        step(1'b1);
        wb_valid = 1'b1;
        wb_tag   = '0;
        wb_value = 8'h55;
        step(1'b1);
        wb_valid     = 1'b0;
        commit_ready = 1'b1;
        #1;
        chk("full_commit_valid", 32'(commit_valid), 32'h1);
        chk("full_no_alloc", 32'(alloc_ready), 32'h0);
        step(1'b1);
        commit_ready = 1'b0;
        #1;
        chk("refill_ready", 32'(alloc_ready), 32'h1);
        chk("refill_tag", 32'(alloc_tag), 32'h0);
        step(1'b1);
        idle();
        #1;
        chk("refill_count", 32'(count), 32'd8);

        // CDB bypass on lookup, then the stored result.
        do_reset();
        alloc(4'b0001, 4'd5);
        alloc(4'b0001, 4'd6);
        rd_tag_a = 3'd1;
        wb_valid = 1'b1;
        wb_tag   = 3'd1;
        wb_value = 8'd5;
        #1;
        chk("byp_ready", 32'(rd_ready_a), 32'h1);
        chk("byp_value", 32'(rd_value_a), 32'd5);
        chk("byp_other", 32'(rd_ready_b), 32'h0);
        step(1'b1);
        wb_valid = 1'b0;
        #1;
        chk("stored_ready", 32'(rd_ready_a), 32'h1);
        chk("stored_value", 32'(rd_value_a), 32'd5);
        step(1'b1);

        // STORE retires without a register write.
        do_reset();
        alloc(4'b0100, 4'd2);
        wb_valid = 1'b1;
        wb_tag   = '0;
        wb_value = 8'd7;
        #1;
        chk("st_same_cycle", 32'(commit_valid), 32'h0);
        step(1'b1);
        idle();
        #1;
        chk("st_valid", 32'(commit_valid), 32'h1);
        chk("st_reg_we", 32'(commit_reg_we), 32'h0);
        chk("st_value", 32'(commit_value), 32'd7);

        // Flush beats simultaneous alloc and writeback.
        do_reset();
        for (int i = 0; i < 5; i++) alloc(4'b0001, 4'(i));
        flush       = 1'b1;
        alloc_valid = 1'b1;
        wb_valid    = 1'b1;
        wb_tag      = 3'd1;
        wb_value    = 8'h99;
        #1;
        chk("flush_pre_count", 32'(count), 32'd5);
        step(1'b1);
        idle();
        #1;
        chk("flush_count", 32'(count), 32'h0);
        chk("flush_empty", 32'(empty), 32'h1);
        chk("flush_tail", 32'(alloc_tag), 32'h0);

        // Reset mid-stream gives the same clean state.
        for (int i = 0; i < 3; i++) alloc(4'b0010, 4'(i));
        wb(0, 8'h12);
        rst_n       = 1'b0;
        alloc_valid = 1'b1;
        wb_valid    = 1'b1;
        wb_tag      = 3'd1;
        step(1'b1);
        idle();
        #1;
        chk("rst_mid_count", 32'(count), 32'h0);
        chk("rst_mid_commit", 32'(commit_valid), 32'h0);
        chk("rst_mid_tail", 32'(alloc_tag), 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            rand_inputs();
            step(1'b1);
        end
        idle();
        step(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rob_param.md
Name: rob_param

Overview:
- Parametrised reorder buffer for the Tomasulo core. It replaces the fixed 8-entry ROB arrays held in the top-level driver.
- Allocates entries in program order at issue, captures results from the common data bus (CDB) and exposes operand lookup for reservation stations.
- Retires completed entries in order to the register file or to memory, and supports a full flush.

Parameters:
- DEPTH, 8, number of ROB entries; must be a power of two, 2..64.
- TAG_W, $clog2(DEPTH), width of the ROB tag/pointer.
- DATA_W, 8, result value width.
- REG_W, 4, architectural register index width (16 registers).
- OP_W, 4, opcode width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  discard all entries this cycle.
- alloc_valid  in  1  issue stage requests an entry.
- alloc_ready  out  1  entry available (= !full).
- alloc_opcode  in  OP_W  opcode of the issuing instruction.
- alloc_dest  in  REG_W  destination register (unused for store).
- alloc_tag  out  TAG_W  tag assigned on a fire (= tail pointer).
- wb_valid  in  1  CDB broadcast valid.
- wb_tag  in  TAG_W  CDB result tag.
- wb_value  in  DATA_W  CDB result value.
- rd_tag_a / rd_tag_b  in  TAG_W  operand lookup tags.
- rd_ready_a / rd_ready_b  out  1  looked-up entry has its value.
- rd_value_a / rd_value_b  out  DATA_W  looked-up value.
- commit_valid  out  1  head entry is complete.
- commit_ready  in  1  consumer accepts the retirement.
- commit_tag  out  TAG_W  head pointer.
- commit_opcode  out  OP_W  head opcode.
- commit_dest  out  REG_W  head destination register.
- commit_value  out  DATA_W  head value.
- commit_reg_we  out  1  commit_valid and opcode is not STORE (0100).
- count  out  TAG_W+1  occupied entries.
- full / empty  out  1  count==DEPTH / count==0.

Behaviour:
- Per-entry state: busy, done, opcode, dest, value. head, tail and count are registers.
- Reset (rst_n=0 at a clock edge):
  - all busy and done bits cleared; head=tail=0; count=0.
  - Resulting outputs: alloc_ready=1, alloc_tag=0, empty=1, full=0, commit_valid=0, commit_reg_we=0, rd_ready_*=0 (no wb that cycle).
  - Reset overrides flush and all other inputs. Reset in mid-operation discards everything with no partial commit.
- Allocate fires on alloc_valid && alloc_ready:
  - entry[tail] gets busy=1, done=0, opcode and dest written.
  - tail = tail+1 mod DEPTH.
  - alloc_tag is combinational and equals the pre-increment tail.
- Writeback: wb_valid with busy[wb_tag]=1 sets done=1 and value=wb_value.
  - wb to a non-busy tag is ignored.
  - wb to an already-done entry overwrites value; the bench treats this as a protocol error, and the RTL should assert it in simulation.
- Commit fires on commit_valid && commit_ready:
  - busy[head] and done[head] cleared; head = head+1 mod DEPTH.
  - commit_valid = !empty && done[head]. Commit outputs are combinational from entry[head], zero latency.
  - A result written on cycle N commits at the earliest on cycle N+1.
- Count: count_next = count + alloc_fire − commit_fire.
  - Simultaneous alloc and commit leaves count unchanged and is legal whenever alloc_ready=1.
  - Allocation is not allowed into a slot freed by a same-cycle commit while full (alloc_ready stays 0 when full).
- Operand lookup (combinational):
  - rd_ready_x = busy[t] && (done[t] || (wb_valid && wb_tag==t)).
  - rd_value_x takes the wb_value bypass when it matches the tag, else value[t].
  - Non-busy tag gives rd_ready_x=0 and rd_value_x=0.
- Flush: on the next edge all busy/done are cleared, head=tail=0, count=0. Flush has priority over same-cycle alloc, wb and commit. Outputs still show pre-flush state during the flush cycle.
- Wrap-around: pointers wrap modulo DEPTH. full/empty are derived from count, not from pointer equality.
- Overflow and underflow are impossible by construction (alloc gated by full, commit gated by empty).

Decomposition:
- Shared package tomasulo_pkg holds:
  - opcode constants OP_SUB=0000, OP_ADD=0001, OP_MUL=0010, OP_DIV=0011, OP_STORE=0100, OP_LOAD=0101;
  - default widths DATA_W=8, REG_W=4, OP_W=4, INST_W=16;
  - a typedef rob_entry_t {busy, done, opcode, dest, value}.
- Single module; no sub-module needed. The lookup port is one function instantiated twice.

Test Plan:
- Reset, then allocate ADD r3 -> alloc_tag=0, count=1. wb tag0 value 8'h2A -> next cycle commit_valid=1, commit_dest=3, commit_value=2A, commit_reg_we=1. commit_ready=1 -> empty=1.
- Out-of-order completion: allocate tags 0,1,2; wb tag2=11 then tag1=22 -> commit_valid stays 0 until tag0 is written (33). Then the commits must appear in order 33, 22, 11.
- Fill 8 entries -> full=1, alloc_ready=0, extra alloc_valid ignored, tail=0. Commit one entry while alloc_valid is held -> alloc fires the following cycle with alloc_tag=0.
- Lookup bypass: rd_tag_a=1 with wb_valid, wb_tag=1, wb_value=5 in the same cycle -> rd_ready_a=1, rd_value_a=5. Next cycle the same result comes from storage.
- STORE allocation with wb value 7 -> commit_valid=1, commit_reg_we=0.
- Flush with 5 entries pending, plus simultaneous alloc and wb -> next cycle count=0, head=tail=0, empty=1. rst_n=0 mid-stream gives the same state.
